test: RTL and testbench



---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/seq_index_counter.sv | 32 +++
 rtl/test.sv | 41 ++++
 tb/tb_test.sv | 112 +++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants and table-lookup helper for the 3-bit sequence generator.
package seq_gen_pkg;

   localparam int SEQ_W   = 3;
   localparam int MAX_LEN = 8;

   localparam logic [MAX_LEN*SEQ_W-1:0] GRAY_TABLE =
      {3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};

   // Entry i lives at bits [3i+2:3i].
   function automatic logic [SEQ_W-1:0] seq_entry(
      input logic [MAX_LEN*SEQ_W-1:0] tbl,
      input logic [2:0]               idx
   );
      seq_entry = tbl[int'(idx)*SEQ_W +: SEQ_W];
   endfunction

endpackage

// File: rtl/seq_index_counter.sv
// Modulo-SEQ_LEN wrapping index counter; out-of-range states fall back to 0.
module seq_index_counter #(
   parameter int SEQ_LEN = 8,
   parameter int IDX_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   output logic [IDX_W-1:0] o_next_idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);

   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_next;

   // ">=" rather than "==" so unreachable codes recover to 0 in one clock.
   always_comb begin
      w_next = '0;
      if (r_idx < LAST)
         w_next = r_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_idx <= '0;
      else
         r_idx <= w_next;
   end

   assign o_next_idx = w_next;

endmodule

// File: rtl/test.sv
// Free-running sequence generator: walks SEQ_TABLE one entry per clock, wrapping
// after SEQ_LEN entries. out is registered alongside the index.
module test
   import seq_gen_pkg::*;
#(
   parameter int                          SEQ_LEN   = 8,
   parameter logic [MAX_LEN*SEQ_W-1:0]    SEQ_TABLE = GRAY_TABLE
) (
   input  logic             clk,
   input  logic             rst,
   output logic [SEQ_W-1:0] out
);

   localparam int IDX_W = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;

   generate
      if (SEQ_LEN < 2 || SEQ_LEN > MAX_LEN) begin : g_bad_len
         $error("test: SEQ_LEN must be in 2..8");
      end
   endgenerate

   logic [IDX_W-1:0] w_next_idx;

   seq_index_counter #(
      .SEQ_LEN (SEQ_LEN),
      .IDX_W   (IDX_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .o_next_idx (w_next_idx)
   );

   // Loading from the next index keeps out == SEQ_TABLE[idx] with no extra latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out <= seq_entry(SEQ_TABLE, 3'd0);
      else
         out <= seq_entry(SEQ_TABLE, 3'(w_next_idx));
   end

endmodule

// File: tb/tb_test.sv
// Directed bench for the sequence generator: default Gray table, SEQ_LEN=5, and a counting table.
module tb_test;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] out8, out5, outc, prev;
   int         checks   = 0;
   int         failures = 0;

   logic [2:0] gray [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                            3'b110, 3'b111, 3'b101, 3'b100};

   test u_dut (
      .clk (clk),
      .rst (rst),
      .out (out8)
   );

   test #(
      .SEQ_LEN (5)
   ) u_len5 (
      .clk (clk),
      .rst (rst),
      .out (out5)
   );

   test #(
      .SEQ_LEN   (8),
      .SEQ_TABLE ({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0})
   ) u_cust (
      .clk (clk),
      .rst (rst),
      .out (outc)
   );

   always #2 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held across clock edges
      rst = 1'b1;
      #1;
      check("rst_t1_def", out8, 3'b000);
      check("rst_t1_len5", out5, 3'b000);
      check("rst_t1_cust", outc, 3'b000);
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_edge_def", out8, 3'b000);
         check("rst_edge_len5", out5, 3'b000);
         check("rst_edge_cust", outc, 3'b000);
      end
      #3;
      @(negedge clk);
      check("rst_hold_def", out8, 3'b000);
      rst = 1'b0;

      // First lap after release
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("lap1_def", out8, gray[(i + 1) % 8]);
         check("lap1_len5", out5, gray[(i + 1) % 5]);
         check("lap1_cust", outc, 3'((i + 1) % 8));
      end

      // Continued running: period and single-bit steps
      prev = out8;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("run_def", out8, gray[(9 + i) % 8]);
         check("run_hamming", 3'($countones(out8 ^ prev)), 3'd1);
         check("run_len5", out5, gray[(9 + i) % 5]);
         check("run_cust", outc, 3'((9 + i) % 8));
         prev = out8;
      end

      // Asynchronous reset mid-sequence
      for (int w = 0; w < 16 && out8 !== 3'b110; w++) begin
         @(posedge clk); #1;
      end
      check("reach_110", out8, 3'b110);
      rst = 1'b1;
      #1;
      check("async_rst_def", out8, 3'b000);
      check("async_rst_len5", out5, 3'b000);
      check("async_rst_cust", outc, 3'b000);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_def", out8, 3'b001);
      check("post_rst_len5", out5, 3'b001);
      check("post_rst_cust", outc, 3'b001);

      // Illegal index recovery for SEQ_LEN=5
      force u_len5.u_cnt.r_idx = 3'd7;
      #1;
      release u_len5.u_cnt.r_idx;
      @(posedge clk); #1;
      check("illegal_recover", out5, 3'b000);
      @(posedge clk); #1;
      check("illegal_next", out5, 3'b001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
